// File: rtl/mutual_rule_scheduler.sv
// rtl/mutual_rule_scheduler.sv - round-robin rule scheduler for the 3-node mutual-exclusion model
// Picks one guard-enabled (rule, node) pair per cycle and drives the registered rule code.
module mutual_rule_scheduler #(
   parameter int NODES     = 3,
   parameter int MAX_STEPS = 255,
   parameter int STEP_W    = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 halt,
   input  logic [2*NODES-1:0]   n_state,
   input  logic                 x,
   output logic [3:0]           io_en_a,
   output logic                 fire,
   output logic [STEP_W-1:0]    steps,
   output logic                 busy,
   output logic                 done,
   output logic                 deadlock,
   output logic                 mutex_err
);

   localparam int N4 = 4 * NODES;
   localparam int PW = $clog2(N4);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_DEAD} state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       rr_q, rr_d;
   logic [STEP_W-1:0]   steps_q, steps_d, steps_inc;
   logic [3:0]          en_q, en_d;
   logic                fire_q, fire_d;
   logic                done_q, done_d;
   logic                dead_q, dead_d;
   logic                mutex_q, mutex_d;

   logic [N4-1:0]       guard;
   logic [2:0]          crit_cnt;
   logic                crit2;
   logic                found;
   logic [PW-1:0]       cand;
   logic [PW-1:0]       sel_k;
   logic [3:0]          sel_code;

   // Guard vector laid out as k = rule*NODES + node.
   always_comb begin
      guard    = '0;
      crit_cnt = '0;
      for (int i = 0; i < NODES; i++) begin
         guard[i]           = (n_state[2*i +: 2] == 2'd0);
         guard[NODES + i]   = (n_state[2*i +: 2] == 2'd1) && x;
         guard[2*NODES + i] = (n_state[2*i +: 2] == 2'd2);
         guard[3*NODES + i] = (n_state[2*i +: 2] == 2'd3);
         crit_cnt           = crit_cnt + {2'b00, (n_state[2*i +: 2] == 2'd2)};
      end
   end

   assign crit2 = (crit_cnt >= 3'd2);

   always_comb begin
      found    = 1'b0;
      cand     = '0;
      sel_k    = '0;
      sel_code = 4'hF;
      for (int off = 1; off <= N4; off++) begin
         cand = PW'((int'(rr_q) + off) % N4);
         if (!found && guard[cand]) begin
            found    = 1'b1;
            sel_k    = cand;
            sel_code = {2'(int'(cand) / NODES), 2'(int'(cand) % NODES)};
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      steps_d   = steps_q;
      en_d      = 4'hF;
      fire_d    = 1'b0;
      done_d    = done_q;
      dead_d    = dead_q;
      mutex_d   = mutex_q | crit2;
      steps_inc = (&steps_q) ? steps_q : steps_q + STEP_W'(1);
      case (state_q)
         S_RUN: begin
            if (!halt) begin
               if (found) begin
                  fire_d  = 1'b1;
                  en_d    = sel_code;
                  rr_d    = sel_k;
                  steps_d = steps_inc;
                  if (MAX_STEPS != 0 && steps_inc == STEP_W'(MAX_STEPS)) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  state_d = S_DEAD;
                  dead_d  = 1'b1;
               end
            end
         end
         default: begin
            // Pointer parks on the last index so the first search of a run starts at k=0.
            if (start) begin
               state_d = S_RUN;
               steps_d = '0;
               done_d  = 1'b0;
               dead_d  = 1'b0;
               mutex_d = crit2;
               rr_d    = PW'(N4 - 1);
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         steps_q <= '0;
         en_q    <= 4'hF;
         fire_q  <= 1'b0;
         done_q  <= 1'b0;
         dead_q  <= 1'b0;
         mutex_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         steps_q <= steps_d;
         en_q    <= en_d;
         fire_q  <= fire_d;
         done_q  <= done_d;
         dead_q  <= dead_d;
         mutex_q <= mutex_d;
      end
   end

   assign io_en_a   = en_q;
   assign fire      = fire_q;
   assign steps     = steps_q;
   assign busy      = (state_q == S_RUN);
   assign done      = done_q;
   assign deadlock  = dead_q;
   assign mutex_err = mutex_q;

endmodule

// File: tb/tb_mutual_rule_scheduler.sv
// tb/tb_mutual_rule_scheduler.sv - scoreboard bench for mutual_rule_scheduler
module tb_mutual_rule_scheduler;

   localparam int NODES = 3;
   localparam int MAXS  = 4;
   localparam int SW    = 16;
   localparam logic [1:0] I = 2'd0, T = 2'd1, C = 2'd2, E = 2'd3;

   logic            clock = 1'b0;
   logic            reset, start, halt, x;
   logic [5:0]      n_state;
   logic [3:0]      io_en_a;
   logic            fire, busy, done, deadlock, mutex_err;
   logic [SW-1:0]   steps;

   always #5 clock = ~clock;

   mutual_rule_scheduler #(.NODES(NODES), .MAX_STEPS(MAXS), .STEP_W(SW)) dut (
      .clock(clock), .reset(reset), .start(start), .halt(halt),
      .n_state(n_state), .x(x), .io_en_a(io_en_a), .fire(fire),
      .steps(steps), .busy(busy), .done(done), .deadlock(deadlock),
      .mutex_err(mutex_err)
   );

   int n_total = 0;
   int n_bad   = 0;
   logic [24:0] exp_q[$];

   int         m_state, m_rr, m_steps;
   logic [3:0] m_en;
   logic       m_fire, m_done, m_dead, m_mutex;

   function automatic logic [5:0] mk(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
      return {c, b, a};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_step(input logic rs, input logic st, input logic hl,
                             input logic [5:0] ns, input logic xv);
      int cnt, k, r, nd;
      logic [1:0] s;
      bit g, found;
      cnt = 0;
      for (int i = 0; i < NODES; i++) if (ns[2*i +: 2] == C) cnt++;
      if (rs) begin
         m_state = 0; m_rr = 0; m_steps = 0; m_en = 4'hF;
         m_fire = 0; m_done = 0; m_dead = 0; m_mutex = 0;
      end else begin
         m_en    = 4'hF;
         m_fire  = 0;
         m_mutex = m_mutex | (cnt >= 2);
         if (m_state == 1) begin
            if (!hl) begin
               found = 0;
               for (int off = 1; off <= 4*NODES && !found; off++) begin
                  k  = (m_rr + off) % (4*NODES);
                  r  = k / NODES;
                  nd = k % NODES;
                  s  = ns[2*nd +: 2];
                  g  = (r == 0 && s == I) || (r == 1 && s == T && xv) ||
                       (r == 2 && s == C) || (r == 3 && s == E);
                  if (g) begin
                     found  = 1;
                     m_rr   = k;
                     m_en   = {2'(r), 2'(nd)};
                     m_fire = 1;
                     if (m_steps < 65535) m_steps++;
                     if (m_steps == MAXS) begin
                        m_state = 2;
                        m_done  = 1;
                     end
                  end
               end
               if (!found) begin
                  m_state = 3;
                  m_dead  = 1;
               end
            end
         end else if (st) begin
            m_state = 1; m_steps = 0; m_done = 0; m_dead = 0;
            m_mutex = (cnt >= 2);
            m_rr    = 4*NODES - 1;
         end
      end
   endtask

   task automatic cyc(input string tag, input logic rs, input logic st, input logic hl,
                      input logic [5:0] ns, input logic xv);
      logic [24:0] got;
      reset = rs; start = st; halt = hl; n_state = ns; x = xv;
      model_step(rs, st, hl, ns, xv);
      exp_q.push_back({m_en, m_fire, 16'(m_steps), (m_state == 1), m_done, m_dead, m_mutex});
      @(posedge clock);
      #1;
      got = {io_en_a, fire, steps, busy, done, deadlock, mutex_err};
      check_eq(tag, 32'(got), 32'(exp_q.pop_front()));
   endtask

   logic [5:0] ens;
   logic       ex;
   int         nfire;

   initial begin
      reset = 1; start = 0; halt = 0; n_state = '0; x = 1;

      // Reset then first grants rotate through Try(0..2).
      for (int c = 0; c < 3; c++) cyc("rst", 1, 0, 0, mk(I, I, I), 1);
      check_eq("rst_en", 32'(io_en_a), 32'hF);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_steps", 32'(steps), 0);
      cyc("s1_start", 0, 1, 0, mk(I, I, I), 1);
      check_eq("s1_busy", 32'(busy), 1);
      check_eq("s1_nofire", 32'(fire), 0);
      cyc("s1_g0", 0, 0, 0, mk(I, I, I), 1);
      check_eq("s1_en0", 32'(io_en_a), 32'h0);
      check_eq("s1_fire0", 32'(fire), 1);
      check_eq("s1_steps1", 32'(steps), 1);
      cyc("s1_g1", 0, 0, 0, mk(I, I, I), 1);
      check_eq("s1_en1", 32'(io_en_a), 32'h1);
      cyc("s1_g2", 0, 0, 0, mk(I, I, I), 1);
      check_eq("s1_en2", 32'(io_en_a), 32'h2);
      cyc("s1_g3", 0, 0, 0, mk(I, I, I), 1);
      check_eq("s1_done", 32'(done), 1);
      check_eq("s1_notbusy", 32'(busy), 0);
      cyc("s1_after", 0, 0, 0, mk(I, I, I), 1);
      check_eq("s1_noop", 32'(io_en_a), 32'hF);

      // Crit grant, then Crit for node1 skipped while x=0.
      cyc("s2_start", 0, 1, 0, mk(I, T, T), 1);
      cyc("s2_try0", 0, 0, 0, mk(I, T, T), 1);
      check_eq("s2_try0", 32'(io_en_a), 32'h0);
      cyc("s2_crit0", 0, 0, 0, mk(T, T, T), 1);
      check_eq("s2_crit0", 32'(io_en_a), 32'h4);
      cyc("s2_exit0", 0, 0, 0, mk(C, T, T), 0);
      check_eq("s2_exit0", 32'(io_en_a), 32'h8);

      // Deadlock (start while running is ignored), then restart.
      cyc("s3_dead", 0, 1, 0, mk(T, T, T), 0);
      check_eq("s3_deadlock", 32'(deadlock), 1);
      check_eq("s3_noop", 32'(io_en_a), 32'hF);
      check_eq("s3_notbusy", 32'(busy), 0);
      cyc("s3_hold", 0, 0, 0, mk(T, T, T), 0);
      cyc("s3_restart", 0, 1, 0, mk(T, T, T), 0);
      check_eq("s3_clear", 32'(deadlock), 0);
      check_eq("s3_busy", 32'(busy), 1);

      // MAX_STEPS with a looping environment.
      cyc("s4_rst", 1, 0, 0, mk(I, I, I), 1);
      ens = mk(I, I, I);
      ex  = 1;
      cyc("s4_start", 0, 1, 0, ens, ex);
      nfire = 0;
      for (int c = 0; c < 10; c++) begin
         cyc("s4_run", 0, 0, 0, ens, ex);
         if (fire && io_en_a[1:0] != 2'd3) begin
            nfire++;
            case (io_en_a[3:2])
               2'd0: ens[{io_en_a[1:0], 1'b0} +: 2] = T;
               2'd1: begin ens[{io_en_a[1:0], 1'b0} +: 2] = C; ex = 0; end
               2'd2: ens[{io_en_a[1:0], 1'b0} +: 2] = E;
               default: begin ens[{io_en_a[1:0], 1'b0} +: 2] = I; ex = 1; end
            endcase
         end
      end
      check_eq("s4_nfire", 32'(nfire), 4);
      check_eq("s4_steps", 32'(steps), 4);
      check_eq("s4_done", 32'(done), 1);
      check_eq("s4_busy", 32'(busy), 0);

      // Mutual-exclusion violation is sticky until reset.
      cyc("s5_start", 0, 1, 0, mk(I, I, I), 1);
      cyc("s5_viol", 0, 0, 0, mk(C, I, C), 0);
      check_eq("s5_mutex", 32'(mutex_err), 1);
      cyc("s5_rec0", 0, 0, 0, mk(I, I, I), 1);
      cyc("s5_rec1", 0, 0, 0, mk(I, I, I), 1);
      check_eq("s5_sticky", 32'(mutex_err), 1);
      cyc("s5_rst", 1, 0, 0, mk(I, I, I), 1);
      check_eq("s5_cleared", 32'(mutex_err), 0);

      // Start with halt, mid-run halt, resume from rr_ptr+1, mid-run reset.
      cyc("s6_start", 0, 1, 1, mk(I, I, I), 1);
      check_eq("s6_busy", 32'(busy), 1);
      cyc("s6_held", 0, 0, 1, mk(I, I, I), 1);
      check_eq("s6_held", 32'(fire), 0);
      cyc("s6_g0", 0, 0, 0, mk(I, I, I), 1);
      check_eq("s6_en0", 32'(io_en_a), 32'h0);
      for (int c = 0; c < 5; c++) begin
         cyc("s6_halt", 0, 0, 1, mk(I, I, I), 1);
         check_eq("s6_halt_fire", 32'(fire), 0);
         check_eq("s6_halt_steps", 32'(steps), 1);
      end
      cyc("s6_resume", 0, 0, 0, mk(I, I, I), 1);
      check_eq("s6_resume", 32'(io_en_a), 32'h1);
      cyc("s6_g2", 0, 0, 0, mk(I, I, I), 1);
      cyc("s6_rst", 1, 1, 0, mk(C, C, I), 1);
      check_eq("s6_rst_en", 32'(io_en_a), 32'hF);
      check_eq("s6_rst_fire", 32'(fire), 0);
      check_eq("s6_rst_steps", 32'(steps), 0);
      check_eq("s6_rst_busy", 32'(busy), 0);
      check_eq("s6_rst_flags", 32'({done, deadlock, mutex_err}), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
